// File: rtl/dbusif_pkg.sv
// Shared types for the pipelined data-bus interface: transfer sizes, the per-stage
// request descriptor and the alignment rule.
package dbusif_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    // Only the low address bits travel in the descriptor; the full address and the
    // store data are held beside it so the data-phase copy carries no dead bits.
    typedef struct packed {
        logic       w_rb;
        size_e      size;
        logic       sgn;
        logic [2:0] lo;
        logic       mis;
    } acc_req_t;

    function automatic logic is_misaligned(input logic [2:0] lo, input size_e size,
                                           input size_e max_size);
        logic [2:0] mask;
        mask = 3'((4'd1 << size) - 4'd1);
        return (size > max_size) || ((lo & mask) != 3'd0);
    endfunction

endpackage

// File: rtl/dbusif_lane_fmt.sv
// Byte-lane formatting: load lane extract with zero/sign extension, and store data
// replication across all byte lanes of the bus.
module dbusif_lane_fmt
    import dbusif_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  size_e             size,
    input  logic              sgn,
    input  logic [2:0]        lo,
    input  logic [DATA_W-1:0] rdata,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] store_data
);

    localparam int BYTES = DATA_W / 8;

    logic [2:0]        off;
    logic [DATA_W-1:0] shifted;
    logic              fill;
    int                nbytes;

    always_comb begin
        off     = lo & 3'(BYTES - 1);
        shifted = rdata >> {off, 3'b000};
        nbytes  = 1 << size;
        // Oversized requests only reach here as faulted completions; keep indices in range.
        if (nbytes > BYTES) nbytes = BYTES;
        fill = sgn & shifted[8*nbytes-1];
        for (int i = 0; i < DATA_W; i++) begin
            load_data[i] = (i < 8*nbytes) ? shifted[i] : fill;
        end
        for (int i = 0; i < BYTES; i++) begin
            store_data[8*i +: 8] = wdata[8*(i % nbytes) +: 8];
        end
    end

endmodule

// File: rtl/dbusif_pipe.sv
// Core load/store to AHB-lite bridge with one address phase and one data phase in
// flight, misalignment faulting without a bus cycle, and replay after a bus ERROR.
module dbusif_pipe
    import dbusif_pkg::*;
#(
    parameter int   ADDR_W    = 32,
    parameter int   DATA_W    = 32,
    parameter logic HPROT_VAL = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              acc_req,
    output logic              acc_rdy,
    input  logic              acc_w_rb,
    input  logic [1:0]        acc_size,
    input  logic              acc_signed,
    input  logic [ADDR_W-1:0] acc_addr,
    input  logic [DATA_W-1:0] acc_wdata,
    output logic              data_vld,
    output logic [DATA_W-1:0] data,
    output logic              data_has_fault,
    output logic              hwrite,
    output logic [ADDR_W-1:0] haddr,
    output logic              hprot,
    output logic [1:0]        hsize,
    output logic [DATA_W-1:0] hwdata,
    output logic              htrans,
    input  logic [DATA_W-1:0] hrdata,
    input  logic              hresp,
    input  logic              hready
);

    localparam size_e MAX_SIZE = (DATA_W == 64) ? SZ_D : SZ_W;

    acc_req_t          new_req;
    acc_req_t          ap;
    acc_req_t          dp;
    logic              ap_vld;
    logic              ap_held;
    logic              dp_vld;
    logic [ADDR_W-1:0] ap_addr;
    logic [DATA_W-1:0] ap_wdata;
    logic [DATA_W-1:0] dp_wdata;
    logic [DATA_W-1:0] load_data;
    logic              accept;
    logic              err_first;
    logic              err_last;
    logic              complete;

    always_comb begin
        new_req.w_rb = acc_w_rb;
        new_req.size = size_e'(acc_size);
        new_req.sgn  = acc_signed;
        new_req.lo   = acc_addr[2:0];
        new_req.mis  = is_misaligned(acc_addr[2:0], size_e'(acc_size), MAX_SIZE);
    end

    // An ERROR is two cycles: hresp with hready low, then hresp with hready high.
    assign err_first = hresp && !hready;
    assign err_last  = hresp && hready;
    assign acc_rdy   = !hresp && (!ap_vld || hready);
    assign accept    = acc_req && acc_rdy;
    assign complete  = dp_vld && hready;

    assign htrans = ap_vld && !ap.mis && !ap_held;
    assign haddr  = ap_addr;
    assign hwrite = ap.w_rb;
    assign hsize  = ap.size;
    assign hprot  = HPROT_VAL;

    dbusif_lane_fmt #(.DATA_W(DATA_W)) u_lane_fmt (
        .size       (dp.size),
        .sgn        (dp.sgn),
        .lo         (dp.lo),
        .rdata      (hrdata),
        .wdata      (dp_wdata),
        .load_data  (load_data),
        .store_data (hwdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ap_vld         <= 1'b0;
            ap_held        <= 1'b0;
            ap             <= '0;
            ap_addr        <= '0;
            ap_wdata       <= '0;
            dp_vld         <= 1'b0;
            dp             <= '0;
            dp_wdata       <= '0;
            data_vld       <= 1'b0;
            data_has_fault <= 1'b0;
            data           <= '0;
        end else begin
            data_vld       <= complete;
            data_has_fault <= complete && (dp.mis || hresp);
            data           <= (complete && !dp.w_rb && !dp.mis && !hresp) ? load_data : '0;

            // The address phase survives the error and is re-driven once held drops.
            if (err_first) begin
                ap_held <= ap_vld;
            end else if (err_last) begin
                ap_held <= 1'b0;
                dp_vld  <= 1'b0;
            end else if (hready) begin
                dp_vld   <= ap_vld;
                dp       <= ap;
                dp_wdata <= ap_wdata;
                ap_vld   <= accept;
            end else if (accept) begin
                ap_vld <= 1'b1;
            end

            if (accept) begin
                ap       <= new_req;
                ap_addr  <= acc_addr;
                ap_wdata <= acc_wdata;
            end
        end
    end

endmodule

// File: tb/tb_dbusif_pipe.sv
// Bench for dbusif_pipe: AHB slave model, request driver, reference-model scoreboard.
module tb_dbusif_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        acc_req = 1'b0;
    logic        acc_rdy;
    logic        acc_w_rb = 1'b0;
    logic [1:0]  acc_size = 2'd0;
    logic        acc_signed = 1'b0;
    logic [31:0] acc_addr = '0;
    logic [31:0] acc_wdata = '0;
    logic        data_vld;
    logic [31:0] data;
    logic        data_has_fault;
    logic        hwrite;
    logic [31:0] haddr;
    logic        hprot;
    logic [1:0]  hsize;
    logic [31:0] hwdata;
    logic        htrans;
    logic [31:0] hrdata;
    logic        hresp;
    logic        hready;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    dbusif_pipe #(.ADDR_W(32), .DATA_W(32), .HPROT_VAL(1'b1)) dut (
        .clk(clk), .rst(rst), .acc_req(acc_req), .acc_rdy(acc_rdy), .acc_w_rb(acc_w_rb),
        .acc_size(acc_size), .acc_signed(acc_signed), .acc_addr(acc_addr),
        .acc_wdata(acc_wdata), .data_vld(data_vld), .data(data),
        .data_has_fault(data_has_fault), .hwrite(hwrite), .haddr(haddr), .hprot(hprot),
        .hsize(hsize), .hwdata(hwdata), .htrans(htrans), .hrdata(hrdata), .hresp(hresp),
        .hready(hready)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [1:0] sz,
                                               input logic sgn);
        longint unsigned v;
        int n;
        v = 0;
        n = 1 << sz;
        for (int k = 0; k < n; k++) v |= longint'((addr + 32'(k)) & 32'hFF) << (8*k);
        if (sgn && n < 4 && v[8*n-1]) v |= ~((64'd1 << (8*n)) - 64'd1);
        return v[31:0];
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] wd, input logic [1:0] sz);
        logic [31:0] r;
        int n;
        n = 1 << sz;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
        return r;
    endfunction

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [1:0]  size;
        logic [31:0] hw;
    } bus_t;

    logic [32:0] exp_q[$];   // {fault, data}
    int          acc_q[$];   // accept cycle, -1 when latency is not checked
    bus_t        bus_q[$];

    // ---------------- AHB slave model ----------------
    logic        s_act = 1'b0, s_write = 1'b0, s_errc = 1'b0;
    logic [31:0] s_addr = '0, s_hw = '0;
    int          s_wait = 0;
    logic        n_act, n_write, n_errc;
    logic [31:0] n_addr, n_hw;
    int          n_wait;
    int          fixed_waits = 0;
    bit          rand_waits = 1'b0;
    logic [7:0]  s_base;

    assign s_base = {s_addr[7:2], 2'b00};
    assign hrdata = {s_base + 8'd3, s_base + 8'd2, s_base + 8'd1, s_base};

    always_comb begin
        hready = 1'b1;
        hresp  = 1'b0;
        if (s_act) begin
            if (s_wait > 0) begin
                hready = 1'b0;
            end else if ((s_addr & ~32'h3) == 32'h40) begin
                hresp  = 1'b1;
                hready = s_errc;
            end
        end
    end

    always @(negedge clk) begin
        bus_t e;
        n_act = s_act; n_write = s_write; n_errc = s_errc;
        n_addr = s_addr; n_hw = s_hw; n_wait = s_wait;
        if (!rst) begin
            if (s_act && hready && !hresp && s_write) chk("hwdata", hwdata, s_hw);
            if (s_act && !hready) begin
                if (s_wait > 0) n_wait = s_wait - 1;
                else n_errc = 1'b1;
            end
            if (hready) begin
                n_act  = htrans;
                n_errc = 1'b0;
                n_wait = rand_waits ? int'($urandom_range(0, 2)) : fixed_waits;
                if (htrans) begin
                    if (bus_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL bus_unexpected actual=haddr %0h required=no transfer", haddr);
                    end else begin
                        e = bus_q.pop_front();
                        chk("haddr", haddr, e.addr);
                        chk("hwrite", hwrite, e.write);
                        chk("hsize", hsize, e.size);
                        n_addr = haddr; n_write = hwrite; n_hw = e.hw;
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            s_act <= 1'b0; s_errc <= 1'b0; s_wait <= 0;
        end else begin
            s_act <= n_act; s_write <= n_write; s_errc <= n_errc;
            s_addr <= n_addr; s_hw <= n_hw; s_wait <= n_wait;
        end
    end

    // ---------------- completion monitor ----------------
    int ht_cnt = 0, ht_pairs = 0, vld_cnt = 0;
    logic ht_prev = 1'b0;

    always @(negedge clk) begin
        logic [32:0] e;
        int a;
        if (htrans) begin
            ht_cnt++;
            if (ht_prev) ht_pairs++;
        end
        ht_prev = htrans;
        if (!rst && data_vld) begin
            vld_cnt++;
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL vld_unexpected actual=data %0h required=no completion", data);
            end else begin
                e = exp_q.pop_front();
                a = acc_q.pop_front();
                chk("data", data, e[31:0]);
                chk("fault", data_has_fault, e[32]);
                if (a >= 0) chk("latency", cyc - a, 3);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic issue(input logic w, input logic [1:0] sz, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wd, input bit lat);
        int t;
        logic mis, fault;
        logic [31:0] d;
        bus_t b;
        @(negedge clk);
        acc_req = 1'b1; acc_w_rb = w; acc_size = sz; acc_signed = sgn;
        acc_addr = addr; acc_wdata = wd;
        t = 0;
        while (!acc_rdy && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!acc_rdy) begin
            checks++; errors++;
            $display("FAIL accept_timeout actual=acc_rdy 0 required=1 within 200 cycles");
            acc_req = 1'b0;
        end else begin
            mis   = (sz == 2'd3) || ((addr & ((32'd1 << sz) - 32'd1)) != 32'd0);
            fault = mis || ((addr & ~32'h3) == 32'h40);
            d     = (w || fault) ? 32'd0 : model_load(addr, sz, sgn);
            exp_q.push_back({fault, d});
            acc_q.push_back(lat ? cyc : -1);
            if (!mis) begin
                b.addr = addr; b.write = w; b.size = sz; b.hw = model_store(wd, sz);
                bus_q.push_back(b);
            end
        end
    endtask

    task automatic idle();
        @(negedge clk);
        acc_req = 1'b0;
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk(name, exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    // ---------------- test sequence ----------------
    initial begin : main
        int ht0, pr0, v0;
        logic [1:0]  sz;
        logic [31:0] addr;

        repeat (3) @(negedge clk);
        chk("rst_htrans", htrans, 0);
        chk("rst_acc_rdy", acc_rdy, 1);
        chk("rst_data_vld", data_vld, 0);
        chk("rst_data", data, 0);
        chk("rst_fault", data_has_fault, 0);
        chk("rst_hprot", hprot, 1);
        chk("rst_haddr", haddr, 0);
        chk("rst_hwdata", hwdata, 0);
        chk("rst_hsize_hwrite", {hsize, hwrite}, 0);
        rst = 1'b0;

        // zero-wait word load: one address cycle, completion three cycles after accept
        ht0 = ht_cnt;
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1);
        idle();
        drain("t1_drain");
        chk("t1_htrans_cycles", ht_cnt - ht0, 1);

        issue(1'b0, 2'd0, 1'b1, 32'h82, 32'h0, 1'b0);
        issue(1'b0, 2'd0, 1'b0, 32'h82, 32'h0, 1'b0);
        issue(1'b0, 2'd1, 1'b1, 32'h82, 32'h0, 1'b0);
        idle();
        drain("t2_drain");

        ht0 = ht_cnt; pr0 = ht_pairs;
        issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b0);
        issue(1'b1, 2'd0, 1'b0, 32'h24, 32'hA5, 1'b0);
        idle();
        drain("t3_drain");
        chk("t3_htrans_cycles", ht_cnt - ht0, 2);
        chk("t3_htrans_back_to_back", ht_pairs - pr0, 1);

        ht0 = ht_cnt;
        issue(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 1'b0);
        issue(1'b0, 2'd1, 1'b0, 32'h31, 32'h0, 1'b0);
        idle();
        drain("t4_drain");
        chk("t4_htrans_cycles", ht_cnt - ht0, 1);

        // error on 0x40 cancels the 0x44 address phase, which is then replayed
        ht0 = ht_cnt; pr0 = ht_pairs;
        issue(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 1'b0);
        issue(1'b0, 2'd2, 1'b0, 32'h44, 32'h0, 1'b0);
        idle();
        drain("t5_drain");
        chk("t5_htrans_cycles", ht_cnt - ht0, 3);
        chk("t5_htrans_pairs", ht_pairs - pr0, 1);

        // reset in the middle of a three-cycle wait state
        fixed_waits = 3;
        issue(1'b0, 2'd2, 1'b0, 32'h50, 32'h0, 1'b0);
        idle();
        @(negedge clk);
        @(negedge clk);
        chk("t6_in_wait", hready, 0);
        rst = 1'b1;
        exp_q.delete(); acc_q.delete(); bus_q.delete();
        @(negedge clk);
        chk("t6_htrans", htrans, 0);
        chk("t6_acc_rdy", acc_rdy, 1);
        chk("t6_data_vld", data_vld, 0);
        rst = 1'b0;
        fixed_waits = 0;
        v0 = vld_cnt;
        repeat (8) @(negedge clk);
        chk("t6_no_completion", vld_cnt - v0, 0);

        // randomized traffic with random wait states
        rand_waits = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) == 0) sz = 2'd3;
            else sz = 2'($urandom_range(0, 2));
            addr = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << sz) - 32'd1);
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), addr, $urandom, 1'b0);
            if ($urandom_range(0, 3) == 0) begin
                idle();
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end
        idle();
        drain("rand_drain");
        rand_waits = 1'b0;
        chk("bus_q_empty", bus_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
